// File: rtl/rf_multiport_sb_if.sv
// Datapath-facing bundle for the multiport register file: two read ports with
// busy status, two writeback ports, the issue mark and the conflict diagnostic.
interface rf_multiport_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] R_reg1;
   logic [ADDR_W-1:0] R_reg2;
   logic [DATA_W-1:0] R_data1;
   logic [DATA_W-1:0] R_data2;
   logic              R_busy1;
   logic              R_busy2;
   logic              W0;
   logic [ADDR_W-1:0] W0_reg;
   logic [DATA_W-1:0] W0_data;
   logic              W1;
   logic [ADDR_W-1:0] W1_reg;
   logic [DATA_W-1:0] W1_data;
   logic              Mark;
   logic [ADDR_W-1:0] Mark_reg;
   logic              Conflict;

   modport master (
      output R_reg1, R_reg2, W0, W0_reg, W0_data, W1, W1_reg, W1_data, Mark, Mark_reg,
      input  R_data1, R_data2, R_busy1, R_busy2, Conflict
   );

   modport slave (
      input  R_reg1, R_reg2, W0, W0_reg, W0_data, W1, W1_reg, W1_data, Mark, Mark_reg,
      output R_data1, R_data2, R_busy1, R_busy2, Conflict
   );
endinterface

// File: rtl/rf_multiport_sb.sv
// Two-write / two-read register file with optional same-cycle bypass, optional
// hardwired zero register and a per-register busy scoreboard.
module rf_multiport_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           CLK,
   input  logic           RST_N,
   rf_multiport_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic              r_conflict;

   logic              w_w0_zero;
   logic              w_w1_zero;
   logic              w_mark_zero;
   logic              w_same;
   logic              w_w0_en;
   logic              w_w1_en;
   logic              w_we0;
   logic              w_mark;
   logic [DEPTH-1:0]  w_clr;
   logic [DEPTH-1:0]  w_set;

   logic              w_h1_w0;
   logic              w_h1_w1;
   logic              w_h2_w0;
   logic              w_h2_w1;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_bz1;
   logic              w_bz2;

   assign w_w0_zero   = (ZERO_REG != 0) && (bus.W0_reg == '0);
   assign w_w1_zero   = (ZERO_REG != 0) && (bus.W1_reg == '0);
   assign w_mark_zero = (ZERO_REG != 0) && (bus.Mark_reg == '0);
   assign w_same      = (bus.W0_reg == bus.W1_reg);

   // Effective enables after discarding writes to the hardwired zero register.
   assign w_w0_en = bus.W0 && !w_w0_zero;
   assign w_w1_en = bus.W1 && !w_w1_zero;
   // Port 0 is dropped when port 1 targets the same register.
   assign w_we0   = w_w0_en && !(w_w1_en && w_same);
   assign w_mark  = bus.Mark && !w_mark_zero;

   assign w_clr = (w_w0_en ? (DEPTH'(1) << bus.W0_reg) : '0)
                | (w_w1_en ? (DEPTH'(1) << bus.W1_reg) : '0);
   assign w_set = w_mark ? (DEPTH'(1) << bus.Mark_reg) : '0;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_we0) begin
            r_mem[bus.W0_reg] <= bus.W0_data;
         end
         if (w_w1_en) begin
            r_mem[bus.W1_reg] <= bus.W1_data;
         end
      end
   end

   // Clear-then-set ordering lets a new producer win over a retiring one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_busy     <= '0;
         r_conflict <= 1'b0;
      end else begin
         r_busy     <= (r_busy & ~w_clr) | w_set;
         r_conflict <= bus.W0 && bus.W1 && w_same && !w_w0_zero;
      end
   end

   assign w_h1_w0 = w_w0_en && (bus.W0_reg == bus.R_reg1);
   assign w_h1_w1 = w_w1_en && (bus.W1_reg == bus.R_reg1);
   assign w_h2_w0 = w_w0_en && (bus.W0_reg == bus.R_reg2);
   assign w_h2_w1 = w_w1_en && (bus.W1_reg == bus.R_reg2);

   always_comb begin
      w_rd1 = r_mem[bus.R_reg1];
      w_rd2 = r_mem[bus.R_reg2];
      w_bz1 = r_busy[bus.R_reg1];
      w_bz2 = r_busy[bus.R_reg2];
      if ((ZERO_REG != 0) && (bus.R_reg1 == '0)) begin
         w_rd1 = '0;
         w_bz1 = 1'b0;
      end
      if ((ZERO_REG != 0) && (bus.R_reg2 == '0)) begin
         w_rd2 = '0;
         w_bz2 = 1'b0;
      end
      if (BYPASS != 0) begin
         if (w_h1_w1) begin
            w_rd1 = bus.W1_data;
         end else if (w_h1_w0) begin
            w_rd1 = bus.W0_data;
         end
         if (w_h2_w1) begin
            w_rd2 = bus.W1_data;
         end else if (w_h2_w0) begin
            w_rd2 = bus.W0_data;
         end
         if (w_h1_w0 || w_h1_w1) begin
            w_bz1 = 1'b0;
         end
         if (w_h2_w0 || w_h2_w1) begin
            w_bz2 = 1'b0;
         end
      end
   end

   assign bus.R_data1  = w_rd1;
   assign bus.R_data2  = w_rd2;
   assign bus.R_busy1  = w_bz1;
   assign bus.R_busy2  = w_bz2;
   assign bus.Conflict = r_conflict;
endmodule

// File: tb/tb_rf_multiport_sb.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share stimulus and
// are compared against a behavioural register-file model.
module tb_rf_multiport_sb;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   rf_multiport_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
   rf_multiport_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

   assign if_b.R_reg1   = if_a.R_reg1;
   assign if_b.R_reg2   = if_a.R_reg2;
   assign if_b.W0       = if_a.W0;
   assign if_b.W0_reg   = if_a.W0_reg;
   assign if_b.W0_data  = if_a.W0_data;
   assign if_b.W1       = if_a.W1;
   assign if_b.W1_reg   = if_a.W1_reg;
   assign if_b.W1_data  = if_a.W1_data;
   assign if_b.Mark     = if_a.Mark;
   assign if_b.Mark_reg = if_a.Mark_reg;

   rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .bus(if_a.slave));
   rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .bus(if_b.slave));

   // Reference model: register contents, busy flags and last-cycle conflict.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_busy [DEPTH];
   bit            m_conf;

   typedef struct {
      logic [DW-1:0] d1, d2, n1, n2;
      logic          b1, b2, nb1, nb2, c;
   } exp_t;

   exp_t sb_q[$];
   event ev_sample;
   int   n_total = 0;
   int   n_bad   = 0;

   function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a, bit byp);
      if (a == 0) return '0;
      if (byp && if_a.W1 && if_a.W1_reg == a) return if_a.W1_data;
      if (byp && if_a.W0 && if_a.W0_reg == a) return if_a.W0_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(logic [AW-1:0] a, bit byp);
      if (a == 0) return 1'b0;
      if (byp && ((if_a.W1 && if_a.W1_reg == a) || (if_a.W0 && if_a.W0_reg == a))) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_conf = 1'b0;
   endtask

   task automatic model_edge();
      bit c;
      c = if_a.W0 && if_a.W1 && (if_a.W0_reg == if_a.W1_reg) && (if_a.W0_reg != 0);
      if (if_a.W0 && if_a.W0_reg != 0) m_mem[if_a.W0_reg] = if_a.W0_data;
      if (if_a.W1 && if_a.W1_reg != 0) m_mem[if_a.W1_reg] = if_a.W1_data;
      if (if_a.W0) m_busy[if_a.W0_reg] = 1'b0;
      if (if_a.W1) m_busy[if_a.W1_reg] = 1'b0;
      if (if_a.Mark && if_a.Mark_reg != 0) m_busy[if_a.Mark_reg] = 1'b1;
      m_conf = c;
   endtask

   task automatic check_now();
      exp_t e;
      #1;
      e.d1  = exp_data(if_a.R_reg1, 1'b1);
      e.d2  = exp_data(if_a.R_reg2, 1'b1);
      e.n1  = exp_data(if_a.R_reg1, 1'b0);
      e.n2  = exp_data(if_a.R_reg2, 1'b0);
      e.b1  = exp_busy(if_a.R_reg1, 1'b1);
      e.b2  = exp_busy(if_a.R_reg2, 1'b1);
      e.nb1 = exp_busy(if_a.R_reg1, 1'b0);
      e.nb2 = exp_busy(if_a.R_reg2, 1'b0);
      e.c   = m_conf;
      sb_q.push_back(e);
      ->ev_sample;
      #1;
   endtask

   task automatic cmp(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(ev_sample);
         if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_empty t=%0t actual=0 required=1 entries", $time);
         end else begin
            e = sb_q.pop_front();
            cmp("byp_data1", if_a.R_data1, e.d1);
            cmp("byp_data2", if_a.R_data2, e.d2);
            cmp("byp_busy1", {31'b0, if_a.R_busy1}, {31'b0, e.b1});
            cmp("byp_busy2", {31'b0, if_a.R_busy2}, {31'b0, e.b2});
            cmp("byp_conflict", {31'b0, if_a.Conflict}, {31'b0, e.c});
            cmp("nob_data1", if_b.R_data1, e.n1);
            cmp("nob_data2", if_b.R_data2, e.n2);
            cmp("nob_busy1", {31'b0, if_b.R_busy1}, {31'b0, e.nb1});
            cmp("nob_busy2", {31'b0, if_b.R_busy2}, {31'b0, e.nb2});
            cmp("nob_conflict", {31'b0, if_b.Conflict}, {31'b0, e.c});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      if_a.W0   = 1'b0;
      if_a.W1   = 1'b0;
      if_a.Mark = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      if (RST_N) model_edge();
      @(negedge CLK);
   endtask

   task automatic wr0(logic [AW-1:0] a, logic [DW-1:0] d);
      if_a.W0 = 1'b1; if_a.W0_reg = a; if_a.W0_data = d;
   endtask

   task automatic wr1(logic [AW-1:0] a, logic [DW-1:0] d);
      if_a.W1 = 1'b1; if_a.W1_reg = a; if_a.W1_data = d;
   endtask

   task automatic mark(logic [AW-1:0] a);
      if_a.Mark = 1'b1; if_a.Mark_reg = a;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   task automatic async_reset_midcycle();
      #1;
      RST_N = 1'b0;
      model_reset();
      idle();
      check_now();
      step();
      RST_N = 1'b1;
   endtask

   initial begin
      idle();
      if_a.W0_reg = '0; if_a.W0_data = '0;
      if_a.W1_reg = '0; if_a.W1_data = '0;
      if_a.Mark_reg = '0;
      if_a.R_reg1 = 5'd7;
      if_a.R_reg2 = 5'd31;
      model_reset();
      @(negedge CLK);
      check_now();
      @(negedge CLK);
      RST_N = 1'b1;
      check_now();

      // Same-cycle bypass, then stored value.
      if_a.R_reg1 = 5'd3;
      wr0(5'd3, 32'hDEADBEEF);
      check_now();
      step();
      idle();
      check_now();

      // Both ports to one register: port 1 wins, one-cycle conflict pulse.
      if_a.R_reg1 = 5'd5;
      wr0(5'd5, 32'h11);
      wr1(5'd5, 32'h22);
      check_now();
      step();
      idle();
      check_now();
      step();
      check_now();

      // Zero register ignores writes and marks.
      if_a.R_reg1 = 5'd0;
      if_a.R_reg2 = 5'd0;
      wr1(5'd0, 32'hFFFFFFFF);
      mark(5'd0);
      check_now();
      step();
      idle();
      check_now();
      wr0(5'd0, 32'h77);
      wr1(5'd0, 32'h88);
      step();
      idle();
      check_now();

      // Busy scoreboard on register 9.
      if_a.R_reg1 = 5'd9;
      if_a.R_reg2 = 5'd3;
      mark(5'd9);
      check_now();
      step();
      idle();
      check_now();
      wr0(5'd9, 32'h5A);
      check_now();
      step();
      idle();
      mark(5'd9);
      wr0(5'd9, 32'h66);
      check_now();
      step();
      idle();
      check_now();

      // Asynchronous reset between clock edges while a conflict is pending.
      if_a.R_reg1 = 5'd4;
      wr0(5'd4, 32'h1234);
      step();
      idle();
      wr0(5'd6, 32'hA);
      wr1(5'd6, 32'hB);
      step();
      idle();
      if_a.R_reg2 = 5'd9;
      check_now();
      async_reset_midcycle();
      check_now();

      for (int n = 0; n < 500; n++) begin
         if_a.W0 = 1'($urandom_range(0, 1));
         if_a.W0_reg = pick_addr();
         if_a.W0_data = $urandom;
         if_a.W1 = 1'($urandom_range(0, 1));
         if_a.W1_reg = ($urandom_range(0, 3) == 0) ? if_a.W0_reg : pick_addr();
         if_a.W1_data = $urandom;
         if_a.Mark = 1'($urandom_range(0, 1));
         if_a.Mark_reg = ($urandom_range(0, 4) == 0) ? if_a.W0_reg : pick_addr();
         case ($urandom_range(0, 3))
            0: if_a.R_reg1 = if_a.W0_reg;
            1: if_a.R_reg1 = if_a.W1_reg;
            2: if_a.R_reg1 = if_a.Mark_reg;
            default: if_a.R_reg1 = pick_addr();
         endcase
         if_a.R_reg2 = ($urandom_range(0, 2) == 0) ? if_a.W1_reg : pick_addr();
         check_now();
         if (n == 250) begin
            async_reset_midcycle();
         end else begin
            step();
         end
      end

      idle();
      check_now();
      #20;
      if (sb_q.size() != 0) begin
         n_total++;
         n_bad++;
         $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
Parametrised successor to the single-write CPU register file. Adds two write ports, optional same-cycle write-to-read bypass, an optional hardwired zero register, asynchronous clear and a per-register busy scoreboard. Sits in the CPU datapath between decode (two reads, one issue-mark per cycle) and writeback (up to two retiring results per cycle).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy
BYPASS, 1, 1 = reads and busy queries see same-cycle writes

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
R_reg1  input  ADDR_W  read port 1 address
R_reg2  input  ADDR_W  read port 2 address
R_data1  output  DATA_W  read port 1 data
R_data2  output  DATA_W  read port 2 data
R_busy1  output  1  register R_reg1 has an outstanding producer
R_busy2  output  1  register R_reg2 has an outstanding producer
W0  input  1  write enable, port 0
W0_reg  input  ADDR_W  write address, port 0
W0_data  input  DATA_W  write data, port 0
W1  input  1  write enable, port 1
W1_reg  input  ADDR_W  write address, port 1
W1_data  input  DATA_W  write data, port 1
Mark  input  1  set busy on Mark_reg (instruction issued)
Mark_reg  input  ADDR_W  destination being issued
Conflict  output  1  registered pulse: both write ports hit the same address in the previous cycle

Behaviour:
- Interface: one clock, CLK. RST_N is asynchronous and active-low. While RST_N=0, all registers are 0, all busy bits are 0 and Conflict=0.
- Register writes:
  - On posedge, W0 writes W0_data to W0_reg and W1 writes W1_data to W1_reg.
  - If both enables are set with equal addresses, port 1 wins and port 0 is dropped.
  - When ZERO_REG=1, writes to address 0 are discarded.
- Reads:
  - Reads are combinational, zero latency.
  - Without bypass, R_dataN = Mem[R_regN]. Address 0 returns 0 when ZERO_REG=1.
  - When BYPASS=1, if R_regN matches an enabled write address this cycle (excluding 0 when ZERO_REG=1), R_dataN returns that write data. Port 1 takes priority over port 0.
  - When BYPASS=0, the old value is returned until the next cycle.
- Busy scoreboard: one bit per register.
  - On posedge, busy[W0_reg] is cleared if W0, and busy[W1_reg] is cleared if W1.
  - Then busy[Mark_reg] is set if Mark. Mark and a write to the same address in the same cycle leave busy=1 (the new producer wins).
  - Busy for register 0 is never set when ZERO_REG=1.
- Busy outputs:
  - R_busyN = busy[R_regN].
  - When BYPASS=1, R_busyN is forced to 0 if an enabled write to R_regN occurs this cycle, because the bypassed data is valid.
  - Mark does not affect R_busyN combinationally; it is visible from the next cycle.
- Conflict:
  - On posedge, Conflict <= W0 & W1 & (W0_reg==W1_reg) & (address nonzero or ZERO_REG=0).
  - It is high for exactly one cycle per conflicting cycle and is a diagnostic only.
- Reset mid-operation: asserting RST_N low at any time immediately clears all storage, busy bits and Conflict, independent of CLK. The first write is accepted on the first posedge after RST_N returns high.
- Writes to a register that is not busy are legal and update data without scoreboard effect.

Test Plan:
1. Reset, then R_reg1=7, R_reg2=31 -> R_data1=0, R_data2=0, R_busy1=R_busy2=0, Conflict=0.
2. W0=1, W0_reg=3, W0_data=32'hDEADBEEF with R_reg1=3 in the same cycle -> R_data1=DEADBEEF combinationally (BYPASS=1); on the next cycle with W0=0 it still reads DEADBEEF. With BYPASS=0, the same-cycle read returns 0.
3. W0 and W1 both to reg 5, data 32'h11 and 32'h22 -> reg5=32'h22 after the edge; Conflict=1 for exactly one cycle, then 0.
4. W1=1, W1_reg=0, W1_data=32'hFFFFFFFF, and Mark reg 0 -> R_data for reg 0 stays 0 and R_busy stays 0 (ZERO_REG=1).
5. Mark reg 9, next cycle R_reg1=9 -> R_busy1=1. Then W0 to reg 9 with data 32'h5A -> same cycle R_busy1=0 and R_data1=32'h5A. Mark and W0 both on reg 9 in the same cycle -> R_busy1=1 afterwards.
6. Write reg 4=32'h1234, then pulse RST_N low mid-cycle without a clock edge -> R_data for reg 4 = 0 immediately and all busy bits = 0.
